// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding, the per-transfer mode
// word latched on start, and the SCK level helper used by the FSM.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SS_SETUP = 3'd1,
        P0       = 3'd2,
        P1       = 3'd3,
        SS_HOLD  = 3'd4
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
        logic ss_hold;
    } spi_mode_t;

    // SCK level for a given state: idle level outside the bit phases, and the
    // leading edge lands on P0 entry when cpha=1, on P1 entry when cpha=0.
    function automatic logic sclk_level(input spi_state_t st, input spi_mode_t m);
        logic lvl_s;
        case (st)
            P0:      lvl_s = m.cpol ^ m.cpha;
            P1:      lvl_s = m.cpol ^ ~m.cpha;
            default: lvl_s = m.cpol;
        endcase
        return lvl_s;
    endfunction

endpackage

// File: rtl/spi_half_period_cnt.sv
// Half-period divisor counter. Counts 0..dvsr_eff-1 and wraps, where a
// divisor of zero behaves as one. tc pulses on the last cycle of each
// half-period; srst holds the count at zero while the master is idle.
module spi_half_period_cnt #(
    parameter int DVSR_W = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              srst,
    input  logic [DVSR_W-1:0] dvsr,
    output logic              tc
);

    logic [DVSR_W-1:0] cnt_r;
    logic [DVSR_W-1:0] dvsr_eff_s;

    // Effective divisor and terminal-count decode.
    always_comb begin
        dvsr_eff_s = (dvsr == {DVSR_W{1'b0}}) ? DVSR_W'(1) : dvsr;
        tc         = ~srst & (cnt_r == (dvsr_eff_s - DVSR_W'(1)));
    end

    // Count register: cleared while idle, wraps at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {DVSR_W{1'b0}};
        end else if (srst) begin
            cnt_r <= {DVSR_W{1'b0}};
        end else if (tc) begin
            cnt_r <= {DVSR_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + DVSR_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: DATA_W-bit full-duplex transfers, all four
// CPOL/CPHA modes, NUM_SS active-low selects with setup/hold phases and an
// optional held select across back-to-back words.
// Optional feature macro: SPI_LSB_FIRST_EN -- when defined, lsb_first picks
// the shift direction per transfer; otherwise transfers are always MSB-first.
module spi_master_multi
    import spi_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NUM_SS = 4,
    parameter  int DVSR_W = 16,
    localparam int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] din,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic              ss_hold,
    output logic [DATA_W-1:0] dout,
    output logic              spi_done_tick,
    output logic              ready,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_SS-1:0] ss_n,
    input  logic              miso
);

    localparam int               BIT_W    = $clog2(DATA_W) + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    spi_state_t        state_r,   state_nxt_s;
    spi_mode_t         mode_r,    mode_nxt_s,  mode_in_s;
    logic [DVSR_W-1:0] dvsr_r,    dvsr_nxt_s;
    logic [SEL_W-1:0]  sel_r,     sel_nxt_s;
    logic              held_r,    held_nxt_s;
    logic [DATA_W-1:0] tx_r,      tx_nxt_s;
    logic [DATA_W-1:0] rx_r,      rx_nxt_s;
    logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_nxt_s;
    logic [DATA_W-1:0] dout_r,    dout_nxt_s;
    logic              tick_r,    tick_nxt_s;
    logic              ready_r,   ready_nxt_s;
    logic              sclk_r,    sclk_nxt_s;
    logic              mosi_r,    mosi_nxt_s;
    logic [NUM_SS-1:0] ss_n_r,    ss_n_nxt_s;
    logic              lsb_req_s;
    logic              tc_s;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_req_s = lsb_first;
`else
    assign lsb_req_s = lsb_first & 1'b0;
`endif

    assign mode_in_s = '{cpol: cpol, cpha: cpha, lsb_first: lsb_req_s, ss_hold: ss_hold};

    // One-hot-low select decode; an out-of-range index asserts nothing.
    function automatic logic [NUM_SS-1:0] sel_decode(input logic [SEL_W-1:0] s);
        logic [NUM_SS-1:0] v;
        v = {NUM_SS{1'b1}};
        for (int i = 0; i < NUM_SS; i++) begin
            if (int'(s) == i) begin
                v[i] = 1'b0;
            end else begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    spi_half_period_cnt #(.DVSR_W(DVSR_W)) u_half_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .srst  (state_r == IDLE),
        .dvsr  (dvsr_r),
        .tc    (tc_s)
    );

    // Next-state, datapath and output decode for the transfer FSM.
    always_comb begin
        state_nxt_s   = state_r;
        mode_nxt_s    = mode_r;
        dvsr_nxt_s    = dvsr_r;
        sel_nxt_s     = sel_r;
        held_nxt_s    = held_r;
        tx_nxt_s      = tx_r;
        rx_nxt_s      = rx_r;
        bit_cnt_nxt_s = bit_cnt_r;
        dout_nxt_s    = dout_r;
        tick_nxt_s    = 1'b0;
        ss_n_nxt_s    = ss_n_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    mode_nxt_s    = mode_in_s;
                    dvsr_nxt_s    = dvsr;
                    sel_nxt_s     = ss_sel;
                    tx_nxt_s      = din;
                    bit_cnt_nxt_s = {BIT_W{1'b0}};
                    held_nxt_s    = 1'b0;
                    if (held_r && (ss_sel == sel_r)) begin
                        // Same slave still selected: no setup phase needed.
                        state_nxt_s = P0;
                    end else begin
                        // Old select (if any) releases in the same cycle.
                        state_nxt_s = SS_SETUP;
                        ss_n_nxt_s  = sel_decode(ss_sel);
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SS_SETUP: begin
                if (tc_s) begin
                    state_nxt_s = P0;
                end else begin
                    state_nxt_s = SS_SETUP;
                end
            end
            P0: begin
                if (tc_s) begin
                    state_nxt_s = P1;
                    if (mode_r.lsb_first) begin
                        rx_nxt_s = {miso, rx_r[DATA_W-1:1]};
                    end else begin
                        rx_nxt_s = {rx_r[DATA_W-2:0], miso};
                    end
                end else begin
                    state_nxt_s = P0;
                end
            end
            P1: begin
                if (tc_s) begin
                    if (bit_cnt_r == LAST_BIT) begin
                        dout_nxt_s = rx_r;
                        tick_nxt_s = 1'b1;
                        if (mode_r.ss_hold) begin
                            state_nxt_s = IDLE;
                            held_nxt_s  = 1'b1;
                        end else begin
                            state_nxt_s = SS_HOLD;
                        end
                    end else begin
                        state_nxt_s   = P0;
                        bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
                        if (mode_r.lsb_first) begin
                            tx_nxt_s = {1'b0, tx_r[DATA_W-1:1]};
                        end else begin
                            tx_nxt_s = {tx_r[DATA_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    state_nxt_s = P1;
                end
            end
            SS_HOLD: begin
                if (tc_s) begin
                    state_nxt_s = IDLE;
                    ss_n_nxt_s  = {NUM_SS{1'b1}};
                end else begin
                    state_nxt_s = SS_HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                held_nxt_s  = 1'b0;
                ss_n_nxt_s  = {NUM_SS{1'b1}};
            end
        endcase

        sclk_nxt_s  = sclk_level(state_nxt_s, mode_nxt_s);
        mosi_nxt_s  = mode_nxt_s.lsb_first ? tx_nxt_s[0] : tx_nxt_s[DATA_W-1];
        ready_nxt_s = (state_nxt_s == IDLE);
    end

    // State, datapath and registered outputs; reset aborts any transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            mode_r    <= '0;
            dvsr_r    <= {DVSR_W{1'b0}};
            sel_r     <= {SEL_W{1'b0}};
            held_r    <= 1'b0;
            tx_r      <= {DATA_W{1'b0}};
            rx_r      <= {DATA_W{1'b0}};
            bit_cnt_r <= {BIT_W{1'b0}};
            dout_r    <= {DATA_W{1'b0}};
            tick_r    <= 1'b0;
            ready_r   <= 1'b1;
            sclk_r    <= 1'b0;
            mosi_r    <= 1'b0;
            ss_n_r    <= {NUM_SS{1'b1}};
        end else begin
            state_r   <= state_nxt_s;
            mode_r    <= mode_nxt_s;
            dvsr_r    <= dvsr_nxt_s;
            sel_r     <= sel_nxt_s;
            held_r    <= held_nxt_s;
            tx_r      <= tx_nxt_s;
            rx_r      <= rx_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            dout_r    <= dout_nxt_s;
            tick_r    <= tick_nxt_s;
            ready_r   <= ready_nxt_s;
            sclk_r    <= sclk_nxt_s;
            mosi_r    <= mosi_nxt_s;
            ss_n_r    <= ss_n_nxt_s;
        end
    end

    assign dout          = dout_r;
    assign spi_done_tick = tick_r;
    assign ready         = ready_r;
    assign sclk          = sclk_r;
    assign mosi          = mosi_r;
    assign ss_n          = ss_n_r;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi (DATA_W=8, NUM_SS=4). A loopback slave
// model shifts a pattern onto miso and captures mosi on the sample edge;
// expected words and tick cycles go into a scoreboard queue at start time.
module tb_spi_master_multi;

`ifdef SPI_LSB_FIRST_EN
    localparam bit LSB_EN = 1'b1;
`else
    localparam bit LSB_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] dout;
        logic [7:0] mosi;
        int         tcyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [15:0] dvsr = 16'd0;
    logic        start = 1'b0;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic        lsb_first = 1'b0;
    logic [1:0]  ss_sel = 2'd0;
    logic        ss_hold = 1'b0;
    logic [7:0]  dout;
    logic        spi_done_tick;
    logic        ready;
    logic        sclk;
    logic        mosi;
    logic [3:0]  ss_n;
    logic        miso = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t exp_q[$];
    int consumed = 0;

    // Slave model state (written only by the slave process).
    int         seen_id = 0;
    int         sidx = 0;
    logic       lead_seen = 1'b0;
    logic       prev_sclk = 1'b0;
    logic [7:0] mosi_cap = 8'h00;
    // Slave configuration (written only by the stimulus).
    int         xfer_id = 0;
    logic [7:0] pat_r = 8'h00;
    logic       s_cpol = 1'b0;
    logic       s_cpha = 1'b0;
    // Tick monitor results (written only by the monitor).
    int         ticks = 0;
    logic [7:0] last_dout = 8'h00;
    logic [7:0] last_cap = 8'h00;
    int         last_cyc = 0;

    spi_master_multi #(.DATA_W(8), .NUM_SS(4), .DVSR_W(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .din           (din),
        .dvsr          (dvsr),
        .start         (start),
        .cpol          (cpol),
        .cpha          (cpha),
        .lsb_first     (lsb_first),
        .ss_sel        (ss_sel),
        .ss_hold       (ss_hold),
        .dout          (dout),
        .spi_done_tick (spi_done_tick),
        .ready         (ready),
        .sclk          (sclk),
        .mosi          (mosi),
        .ss_n          (ss_n),
        .miso          (miso)
    );

    always #5 clk = ~clk;

    // Cycle counter, advanced on every active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Loopback slave: samples mosi and advances miso on the SPI sample edge.
    always @(negedge clk) begin
        if (seen_id != xfer_id) begin
            seen_id   <= xfer_id;
            sidx      <= 0;
            lead_seen <= 1'b0;
            mosi_cap  <= 8'h00;
            miso      <= pat_r[7];
        end else if (sclk != prev_sclk) begin
            lead_seen <= (prev_sclk == s_cpol);
            if ((prev_sclk == s_cpol) ? !s_cpha : (s_cpha && lead_seen)) begin
                mosi_cap <= {mosi_cap[6:0], mosi};
                if (sidx < 7) miso <= pat_r[6 - sidx];
                else          miso <= 1'b0;
                sidx <= sidx + 1;
            end
        end
        prev_sclk <= sclk;
    end

    // Tick monitor: records what the DUT produced at each done tick.
    always @(negedge clk) begin
        if (spi_done_tick) begin
            ticks     <= ticks + 1;
            last_dout <= dout;
            last_cap  <= mosi_cap;
            last_cyc  <= cyc;
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Start one transfer once ready and push its expected result.
    task automatic xfer(input logic [7:0] d, input logic [7:0] pat, input logic [1:0] sel,
                        input logic hold, input logic pol, input logic pha, input logic lsb,
                        input logic [15:0] dv, input int lat);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("ready_timeout", 32'd0, 32'd1);
        din       = d;
        ss_sel    = sel;
        ss_hold   = hold;
        cpol      = pol;
        cpha      = pha;
        lsb_first = lsb;
        dvsr      = dv;
        start     = 1'b1;
        pat_r     = pat;
        s_cpol    = pol;
        s_cpha    = pha;
        xfer_id   = xfer_id + 1;
        e.dout = (lsb && LSB_EN) ? rev8(pat) : pat;
        e.mosi = (lsb && LSB_EN) ? rev8(d)   : d;
        e.tcyc = cyc + lat;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for the next tick and compare it with the scoreboard.
    task automatic wait_tick(input string tag);
        int   guard;
        exp_t e;
        guard = 0;
        while (ticks <= consumed && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (ticks > consumed) begin
            consumed++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({tag, "_dout"}, 32'(last_dout), 32'(e.dout));
                check({tag, "_mosi"}, 32'(last_cap),  32'(e.mosi));
                check({tag, "_tick_cycle"}, last_cyc, e.tcyc);
            end else begin
                check({tag, "_unexpected_tick"}, 32'd1, 32'd0);
            end
        end else begin
            check({tag, "_tick_timeout"}, 32'd0, 32'd1);
            if (exp_q.size() > 0) e = exp_q.pop_front();
        end
    endtask

    initial begin
        int   t0;
        exp_t dump;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ss_n",  32'(ss_n),  32'hF);
        check("rst_sclk",  32'(sclk),  32'd0);
        check("rst_mosi",  32'(mosi),  32'd0);
        check("rst_dout",  32'(dout),  32'd0);
        check("rst_tick",  32'(spi_done_tick), 32'd0);
        reset_n = 1'b1;

        // Mode 0, 0xA5 out / 0x3C in, tick 35 cycles after start
        xfer(8'hA5, 8'h3C, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 35);
        check("m0_setup_ready", 32'(ready), 32'd0);
        check("m0_setup_ss_n",  32'(ss_n),  32'hE);
        check("m0_setup_mosi",  32'(mosi),  32'd1);
        check("m0_setup_sclk",  32'(sclk),  32'd0);
        wait_tick("m0");
        wait_cyc(last_cyc + 1);
        check("m0_ss_still_low", 32'(ss_n), 32'hE);
        wait_cyc(last_cyc + 2);
        check("m0_ss_released", 32'(ss_n), 32'hF);

        // Modes 1..3: idle level follows cpol, same loopback data
        for (int m = 1; m < 4; m++) begin
            xfer(8'hA5, 8'h3C, 2'd0, 1'b0, m[1], m[0], 1'b0, 16'd2, 35);
            check("mode_setup_sclk", 32'(sclk), 32'(m[1]));
            wait_tick("mode");
            wait_cyc(last_cyc + 2);
            check("mode_idle_sclk", 32'(sclk), 32'(m[1]));
        end

        // Held select on slave 2 across two words
        xfer(8'h11, 8'h5A, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 35);
        wait_tick("hold1");
        wait_cyc(last_cyc + 3);
        check("hold_gap_ss_n",  32'(ss_n),  32'hB);
        check("hold_gap_ready", 32'(ready), 32'd1);
        xfer(8'h22, 8'hC3, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 33);
        check("hold2_ss_n", 32'(ss_n), 32'hB);
        wait_tick("hold2");
        wait_cyc(last_cyc + 2);
        check("hold2_released", 32'(ss_n), 32'hF);

        // Change of slave while a select is held
        xfer(8'h33, 8'h96, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 35);
        wait_tick("sw1");
        wait_cyc(last_cyc + 1);
        check("sw_held_ss_n", 32'(ss_n), 32'hD);
        xfer(8'h44, 8'h69, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 35);
        check("sw_switch_ss_n", 32'(ss_n), 32'h7);
        wait_tick("sw2");
        wait_cyc(last_cyc + 2);
        check("sw_released", 32'(ss_n), 32'hF);

        // dvsr=1 and dvsr=0 give identical timing
        xfer(8'h5A, 8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 18);
        wait_tick("dv1");
        xfer(8'h5A, 8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 18);
        wait_tick("dv0");

        // Start while busy is ignored
        t0 = ticks;
        xfer(8'hC3, 8'h5A, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 35);
        repeat (10) @(negedge clk);
        din    = 8'hFF;
        ss_sel = 2'd3;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_tick("busy");
        wait_cyc(last_cyc + 40);
        check("busy_one_tick", 32'(ticks - t0), 32'd1);

        // Reset mid-word aborts asynchronously with no tick
        t0 = ticks;
        xfer(8'h96, 8'hF0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 35);
        repeat (12) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_ss_n",  32'(ss_n),  32'hF);
        check("abort_sclk",  32'(sclk),  32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_tick",  32'(spi_done_tick), 32'd0);
        if (exp_q.size() > 0) dump = exp_q.pop_front();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (50) @(negedge clk);
        check("abort_no_tick", 32'(ticks - t0), 32'd0);

        // Bit order: lsb_first honoured only when the feature is built in
        xfer(8'h01, 8'h3C, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 35);
        check("lsb_first_bit", 32'(mosi), LSB_EN ? 32'd1 : 32'd0);
        wait_tick("lsb");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
